// File: rtl/usb_hid_mouse_in_responder.sv
// ----------------------------------------------------------------------------
// usb_hid_mouse_in_responder
//
// Device-side interrupt-IN endpoint for a HID boot-protocol mouse.
// This block collects button and motion input between host polls. It answers
// IN tokens addressed to this endpoint with one of the following:
//   - a data report (DATA0/DATA1),
//   - NAK,
//   - STALL.
// It also keeps the data toggle. A report that the host did not ACK is held
// and sent again, unchanged, on the next IN.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            endpoint configured; low clears all state and outputs
//   device_addr       address this device answers to
//   endpoint          interrupt IN endpoint number
//   halt              endpoint halted: answer STALL
//   toggle_clear      pulse: next data packet uses DATA0, drop held snapshot
//   in_buttons        button bitmap, latched on in_update
//   in_dx/dy/wheel    signed deltas, accumulated on in_update
//   in_update         pulse: qualify the input fields above
//   tok_valid/pid/addr/endp   token from the packet RX layer
//   hs_valid/hs_pid   handshake from the host
//   tx_start/tx_pid   start of a response packet and its PID
//   tx_data/_valid/_last/_ready  payload byte stream (valid/ready)
//   tx_done           packet fully sent on the wire
//   data_toggle       PID of the next new data packet (0 = DATA0)
//   report_pending    unsent input exists
//   ack_count         wrapping count of ACKed reports
// ----------------------------------------------------------------------------
module usb_hid_mouse_in_responder #(
    parameter int REPORT_BYTES    = 4,
    parameter int ACK_TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [6:0]  device_addr,
    input  logic [3:0]  endpoint,
    input  logic        halt,
    input  logic        toggle_clear,
    input  logic [7:0]  in_buttons,
    input  logic [7:0]  in_dx,
    input  logic [7:0]  in_dy,
    input  logic [7:0]  in_wheel,
    input  logic        in_update,
    input  logic        tok_valid,
    input  logic [3:0]  tok_pid,
    input  logic [6:0]  tok_addr,
    input  logic [3:0]  tok_endp,
    input  logic        hs_valid,
    input  logic [3:0]  hs_pid,
    output logic        tx_start,
    output logic [3:0]  tx_pid,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    output logic        tx_data_last,
    input  logic        tx_data_ready,
    input  logic        tx_done,
    output logic        data_toggle,
    output logic        report_pending,
    output logic [15:0] ack_count
);

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [1:0] LAST_IDX = 2'(REPORT_BYTES - 1);
    localparam int         TIMER_W  = (ACK_TIMEOUT_CYC < 2) ? 1 : $clog2(ACK_TIMEOUT_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(ACK_TIMEOUT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HS,
        ST_SEND_DATA,
        ST_WAIT_TXDONE,
        ST_WAIT_ACK
    } state_t;

    // Add a delta to an accumulator. The result is clamped to [-127,+127],
    // so -128 never appears in a report.
    function automatic logic signed [7:0] sat_add(input logic signed [7:0] a,
                                                  input logic signed [7:0] b);
        logic signed [8:0] s;
        s = $signed({a[7], a}) + $signed({b[7], b});
        if (s > 9'sd127)
            return 8'sd127;
        else if (s < -9'sd127)
            return -8'sd127;
        else
            return $signed(s[7:0]);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic                r_tx_start;
    logic [3:0]          r_tx_pid;
    logic [1:0]          r_byte_idx;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_toggle;
    logic                r_retx_valid;
    logic                r_pending;
    logic [15:0]         r_ack_count;
    logic signed [7:0]   r_acc_x, r_acc_y, r_acc_w;
    logic [7:0]          r_btn;
    logic [7:0]          r_last_btn;   // buttons of the last report snapshot
    logic [7:0]          r_snap_btn;
    logic signed [7:0]   r_snap_x, r_snap_y, r_snap_w;

    state_t              w_state_nxt;
    logic                w_tx_start_nxt;
    logic [3:0]          w_tx_pid_nxt;
    logic [1:0]          w_byte_idx_nxt;
    logic [TIMER_W-1:0]  w_timer_nxt;
    logic                w_toggle_nxt;
    logic                w_retx_nxt;
    logic                w_pending_nxt;
    logic [15:0]         w_ack_nxt;
    logic signed [7:0]   w_acc_x_nxt, w_acc_y_nxt, w_acc_w_nxt;
    logic [7:0]          w_btn_nxt;
    logic [7:0]          w_last_btn_nxt;
    logic [7:0]          w_snap_btn_nxt;
    logic signed [7:0]   w_snap_x_nxt, w_snap_y_nxt, w_snap_w_nxt;

    logic                w_match;
    logic                w_wheel_moved;
    logic [3:0]          w_data_pid;
    logic [7:0]          w_byte;

    assign w_match = tok_valid && (tok_pid == PID_IN) &&
                     (tok_addr == device_addr) && (tok_endp == endpoint);

    // A 3-byte report has no wheel byte, so wheel motion alone is not
    // treated as new input.
    assign w_wheel_moved = (REPORT_BYTES == 4) && (in_wheel != 8'd0);

    assign w_data_pid = r_toggle ? PID_DATA1 : PID_DATA0;

    // ------------------------------------------------------------------------
    // Next-state and next-register logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first. Then no path
        // through the case can leave it unassigned, and no latch is inferred.
        w_state_nxt    = r_state;
        w_tx_start_nxt = 1'b0;
        w_tx_pid_nxt   = r_tx_pid;
        w_byte_idx_nxt = r_byte_idx;
        w_timer_nxt    = r_timer;
        w_toggle_nxt   = r_toggle;
        w_retx_nxt     = r_retx_valid;
        w_pending_nxt  = r_pending;
        w_ack_nxt      = r_ack_count;
        w_acc_x_nxt    = r_acc_x;
        w_acc_y_nxt    = r_acc_y;
        w_acc_w_nxt    = r_acc_w;
        w_btn_nxt      = r_btn;
        w_last_btn_nxt = r_last_btn;
        w_snap_btn_nxt = r_snap_btn;
        w_snap_x_nxt   = r_snap_x;
        w_snap_y_nxt   = r_snap_y;
        w_snap_w_nxt   = r_snap_w;

        case (r_state)
            ST_IDLE: begin
                if (w_match) begin
                    w_tx_start_nxt = 1'b1;
                    if (halt) begin
                        // STALL wins even over a held snapshot.
                        // The snapshot is kept for later.
                        w_tx_pid_nxt = PID_STALL;
                        w_state_nxt  = ST_SEND_HS;
                    end else if (r_retx_valid) begin
                        // Resend the snapshot with the same PID.
                        w_tx_pid_nxt   = w_data_pid;
                        w_byte_idx_nxt = 2'd0;
                        w_state_nxt    = ST_SEND_DATA;
                    end else if (r_pending) begin
                        w_snap_btn_nxt = r_btn;
                        w_snap_x_nxt   = r_acc_x;
                        w_snap_y_nxt   = r_acc_y;
                        w_snap_w_nxt   = r_acc_w;
                        w_last_btn_nxt = r_btn;
                        w_acc_x_nxt    = 8'sd0;
                        w_acc_y_nxt    = 8'sd0;
                        w_acc_w_nxt    = 8'sd0;
                        w_pending_nxt  = 1'b0;
                        w_retx_nxt     = 1'b1;
                        w_tx_pid_nxt   = w_data_pid;
                        w_byte_idx_nxt = 2'd0;
                        w_state_nxt    = ST_SEND_DATA;
                    end else begin
                        w_tx_pid_nxt = PID_NAK;
                        w_state_nxt  = ST_SEND_HS;
                    end
                end
            end

            ST_SEND_HS: begin
                if (tx_done) begin
                    w_tx_pid_nxt = 4'd0;
                    w_state_nxt  = ST_IDLE;
                end
            end

            ST_SEND_DATA: begin
                // tx_data_valid is high for the whole state, so ready alone
                // marks a byte as accepted.
                if (tx_data_ready) begin
                    if (r_byte_idx == LAST_IDX) begin
                        w_byte_idx_nxt = 2'd0;
                        w_state_nxt    = ST_WAIT_TXDONE;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                    end
                end
            end

            ST_WAIT_TXDONE: begin
                if (tx_done) begin
                    w_timer_nxt = TIMER_LOAD;
                    w_state_nxt = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                if (hs_valid && (hs_pid == PID_ACK)) begin
                    w_toggle_nxt = ~r_toggle;
                    w_retx_nxt   = 1'b0;
                    w_ack_nxt    = r_ack_count + 16'd1;
                    w_tx_pid_nxt = 4'd0;
                    w_state_nxt  = ST_IDLE;
                end else if (hs_valid || (r_timer <= TIMER_W'(1))) begin
                    // No ACK. Keep retx_valid and the toggle, so the next IN
                    // repeats the same packet.
                    w_tx_pid_nxt = 4'd0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end

            default: begin
                w_tx_pid_nxt = 4'd0;
                w_state_nxt  = ST_IDLE;
            end
        endcase

        // Input accumulation is applied after the snapshot decision.
        // An update in the snapshot cycle therefore adds into the freshly
        // cleared accumulators. It is compared against the buttons that
        // were just snapshotted.
        if (in_update) begin
            w_btn_nxt   = in_buttons;
            w_acc_x_nxt = sat_add(w_acc_x_nxt, $signed(in_dx));
            w_acc_y_nxt = sat_add(w_acc_y_nxt, $signed(in_dy));
            w_acc_w_nxt = sat_add(w_acc_w_nxt, $signed(in_wheel));
            if ((in_buttons != w_last_btn_nxt) || (in_dx != 8'd0) ||
                (in_dy != 8'd0) || w_wheel_moved)
                w_pending_nxt = 1'b1;
        end

        // toggle_clear overrides everything else. A discarded snapshot is
        // lost: it is not merged back into the accumulators.
        if (toggle_clear) begin
            w_toggle_nxt = 1'b0;
            w_retx_nxt   = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tx_start   <= 1'b0;
            r_tx_pid     <= 4'd0;
            r_byte_idx   <= 2'd0;
            r_timer      <= '0;
            r_toggle     <= 1'b0;
            r_retx_valid <= 1'b0;
            r_pending    <= 1'b0;
            r_ack_count  <= 16'd0;
            r_acc_x      <= 8'sd0;
            r_acc_y      <= 8'sd0;
            r_acc_w      <= 8'sd0;
            r_btn        <= 8'd0;
            r_last_btn   <= 8'd0;
            r_snap_btn   <= 8'd0;
            r_snap_x     <= 8'sd0;
            r_snap_y     <= 8'sd0;
            r_snap_w     <= 8'sd0;
        end else if (!enable) begin
            // When the endpoint is unconfigured, everything is cleared.
            // This also aborts a packet in flight.
            r_state      <= ST_IDLE;
            r_tx_start   <= 1'b0;
            r_tx_pid     <= 4'd0;
            r_byte_idx   <= 2'd0;
            r_timer      <= '0;
            r_toggle     <= 1'b0;
            r_retx_valid <= 1'b0;
            r_pending    <= 1'b0;
            r_ack_count  <= 16'd0;
            r_acc_x      <= 8'sd0;
            r_acc_y      <= 8'sd0;
            r_acc_w      <= 8'sd0;
            r_btn        <= 8'd0;
            r_last_btn   <= 8'd0;
            r_snap_btn   <= 8'd0;
            r_snap_x     <= 8'sd0;
            r_snap_y     <= 8'sd0;
            r_snap_w     <= 8'sd0;
        end else begin
            // NOTE: non-blocking assignments here. Every register samples
            // the values from before this edge, whatever the statement order.
            r_state      <= w_state_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_tx_pid     <= w_tx_pid_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_timer      <= w_timer_nxt;
            r_toggle     <= w_toggle_nxt;
            r_retx_valid <= w_retx_nxt;
            r_pending    <= w_pending_nxt;
            r_ack_count  <= w_ack_nxt;
            r_acc_x      <= w_acc_x_nxt;
            r_acc_y      <= w_acc_y_nxt;
            r_acc_w      <= w_acc_w_nxt;
            r_btn        <= w_btn_nxt;
            r_last_btn   <= w_last_btn_nxt;
            r_snap_btn   <= w_snap_btn_nxt;
            r_snap_x     <= w_snap_x_nxt;
            r_snap_y     <= w_snap_y_nxt;
            r_snap_w     <= w_snap_w_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_byte = 8'd0;
        case (r_byte_idx)
            2'd0:    w_byte = r_snap_btn;
            2'd1:    w_byte = r_snap_x;
            2'd2:    w_byte = r_snap_y;
            default: w_byte = r_snap_w;
        endcase
    end

    // All outputs are gated by enable, so they drop in the same cycle that
    // enable falls. There is no wait for the register clear.
    assign tx_start       = enable & r_tx_start;
    assign tx_pid         = enable ? r_tx_pid : 4'd0;
    assign tx_data_valid  = enable & (r_state == ST_SEND_DATA);
    assign tx_data        = tx_data_valid ? w_byte : 8'd0;
    assign tx_data_last   = tx_data_valid & (r_byte_idx == LAST_IDX);
    assign data_toggle    = enable & r_toggle;
    assign report_pending = enable & r_pending;
    assign ack_count      = enable ? r_ack_count : 16'd0;

endmodule

// File: tb/tb_usb_hid_mouse_in_responder.sv
// ----------------------------------------------------------------------------
// tb_usb_hid_mouse_in_responder
//
// Directed bench for the HID mouse interrupt-IN responder.
// A transaction-level model in the bench builds the expected reports. It
// accumulates the deltas with integer clamping, decides the response to
// each token, and queues the expected packet.
// A compare process watches tx_start and the payload stream on every cycle.
// Literal checks pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_usb_hid_mouse_in_responder;

    localparam int         NB   = 4;
    localparam int         TO   = 40;
    localparam logic [6:0] ADDR = 7'h15;
    localparam logic [3:0] EP   = 4'h1;

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, halt, toggle_clear;
    logic [6:0]  device_addr;
    logic [3:0]  endpoint;
    logic [7:0]  in_buttons, in_dx, in_dy, in_wheel;
    logic        in_update;
    logic        tok_valid;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        hs_valid;
    logic [3:0]  hs_pid;
    logic        tx_start;
    logic [3:0]  tx_pid;
    logic [7:0]  tx_data;
    logic        tx_data_valid, tx_data_last, tx_data_ready, tx_done;
    logic        data_toggle, report_pending;
    logic [15:0] ack_count;

    usb_hid_mouse_in_responder #(
        .REPORT_BYTES   (NB),
        .ACK_TIMEOUT_CYC(TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .device_addr   (device_addr),
        .endpoint      (endpoint),
        .halt          (halt),
        .toggle_clear  (toggle_clear),
        .in_buttons    (in_buttons),
        .in_dx         (in_dx),
        .in_dy         (in_dy),
        .in_wheel      (in_wheel),
        .in_update     (in_update),
        .tok_valid     (tok_valid),
        .tok_pid       (tok_pid),
        .tok_addr      (tok_addr),
        .tok_endp      (tok_endp),
        .hs_valid      (hs_valid),
        .hs_pid        (hs_pid),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_last  (tx_data_last),
        .tx_data_ready (tx_data_ready),
        .tx_done       (tx_done),
        .data_toggle   (data_toggle),
        .report_pending(report_pending),
        .ack_count     (ack_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]      pid;
        logic            is_data;
        logic [3:0][7:0] b;       // b[0] = buttons ... b[3] = wheel
    } pkt_t;

    pkt_t exp_q[$];

    int              m_x, m_y, m_w, m_ack;
    logic [7:0]      m_btn, m_last_btn;
    bit              m_pending, m_toggle, m_retx;
    logic [3:0][7:0] m_snap;

    function automatic int clamp(input int v);
        if (v > 127)  return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_w = 0; m_ack = 0;
        m_btn = 8'd0; m_last_btn = 8'd0;
        m_pending = 0; m_toggle = 0; m_retx = 0;
        m_snap = '0;
    endtask

    // ------------------------------------------------------------------------
    // Compare process: packet stream against the expected queue
    // ------------------------------------------------------------------------
    pkt_t            cur = '0;
    int              bi  = 0;
    logic [3:0][7:0] cap = '0;
    logic [3:0]      cap_pid = 4'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                cap_pid = tx_pid;
                cap     = '0;
                bi      = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", {28'd0, tx_pid}, 32'hFFFF_FFFF);
                    cur = '0;
                end else begin
                    cur = exp_q.pop_front();
                    check("tx_pid", {28'd0, tx_pid}, {28'd0, cur.pid});
                end
            end
            if (tx_data_valid) begin
                if (!cur.is_data || bi >= NB) begin
                    check("unexpected_data", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_data", {24'd0, tx_data}, {24'd0, cur.b[bi]});
                    check("tx_data_last", {31'd0, tx_data_last}, {31'd0, (bi == NB - 1)});
                    if (tx_data_ready) begin
                        cap[bi] = tx_data;
                        bi++;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [7:0] btn, input int dx, input int dy, input int wh);
        m_x = clamp(m_x + dx);
        m_y = clamp(m_y + dy);
        m_w = clamp(m_w + wh);
        m_btn = btn;
        if (btn != m_last_btn || dx != 0 || dy != 0 || wh != 0) m_pending = 1;
        in_buttons = btn; in_dx = 8'(dx); in_dy = 8'(dy); in_wheel = 8'(wh);
        in_update = 1'b1;
        tick();
        in_update = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic pulse_toggle_clear();
        m_toggle = 0;
        m_retx   = 0;
        toggle_clear = 1'b1;
        tick();
        toggle_clear = 1'b0;
    endtask

    task automatic hs(input logic [3:0] pid);
        if (pid == PID_ACK) begin
            m_toggle = ~m_toggle;
            m_retx   = 0;
            m_ack++;
        end
        hs_valid = 1'b1; hs_pid = pid;
        tick();
        hs_valid = 1'b0; hs_pid = 4'd0;
        tick();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_toggle"},  {31'd0, data_toggle},    {31'd0, m_toggle});
        check({tag, "_pending"}, {31'd0, report_pending}, {31'd0, m_pending});
        check({tag, "_acks"},    {16'd0, ack_count},      m_ack);
    endtask

    // Drive the payload as the packet layer would. Optionally hold ready low
    // before byte stall_at, or drop enable before byte abort_at.
    task automatic serve_data(input int stall_at, input int stall_len, input int abort_at);
        int idx, st, guard;
        bit done, aborted;
        idx = 0; st = 0; guard = 0; done = 0; aborted = 0;
        while (!done && !aborted && guard < 100) begin
            if (idx == abort_at) begin
                enable  = 1'b0;
                aborted = 1;
            end else begin
                if (idx == stall_at && st < stall_len) begin
                    tx_data_ready = 1'b0;
                    st++;
                end else begin
                    tx_data_ready = 1'b1;
                end
                @(negedge clk);
                if (tx_data_valid && tx_data_ready) begin
                    if (tx_data_last) done = 1;
                    idx++;
                end
                tick();
                guard++;
            end
        end
        tx_data_ready = 1'b1;
        if (!aborted) begin
            check("data_phase_done", {31'd0, done}, 32'd1);
            repeat (2) tick();
            pulse_done();
        end
    endtask

    task automatic token(input logic [6:0] a, input logic [3:0] e,
                         input int stall_at, input int stall_len, input int abort_at);
        int   kind;
        pkt_t p;
        kind = 0;
        p    = '0;
        if (a == ADDR && e == EP) begin
            if (halt) begin
                kind = 1; p.pid = PID_STALL;
            end else if (m_retx) begin
                kind = 2; p.is_data = 1'b1; p.b = m_snap;
                p.pid = m_toggle ? PID_DATA1 : PID_DATA0;
            end else if (m_pending) begin
                m_snap[0] = m_btn;
                m_snap[1] = 8'(m_x);
                m_snap[2] = 8'(m_y);
                m_snap[3] = 8'(m_w);
                m_x = 0; m_y = 0; m_w = 0;
                m_pending = 0; m_last_btn = m_btn; m_retx = 1;
                kind = 2; p.is_data = 1'b1; p.b = m_snap;
                p.pid = m_toggle ? PID_DATA1 : PID_DATA0;
            end else begin
                kind = 1; p.pid = PID_NAK;
            end
            exp_q.push_back(p);
        end
        tok_valid = 1'b1; tok_pid = PID_IN; tok_addr = a; tok_endp = e;
        tick();
        tok_valid = 1'b0; tok_pid = 4'd0;
        // The response must start exactly one cycle after the token.
        check("tx_start_latency", {31'd0, tx_start}, {31'd0, (kind != 0)});
        if (kind == 1) begin
            repeat (2) tick();
            pulse_done();
        end else if (kind == 2) begin
            serve_data(stall_at, stall_len, abort_at);
        end else begin
            repeat (3) tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"}, {31'd0, tx_start},      32'd0);
        check({tag, "_tx_pid"},   {28'd0, tx_pid},        32'd0);
        check({tag, "_valid"},    {31'd0, tx_data_valid}, 32'd0);
        check({tag, "_data"},     {24'd0, tx_data},       32'd0);
        check({tag, "_last"},     {31'd0, tx_data_last},  32'd0);
        check({tag, "_toggle"},   {31'd0, data_toggle},   32'd0);
        check({tag, "_pending"},  {31'd0, report_pending},32'd0);
        check({tag, "_acks"},     {16'd0, ack_count},     32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; enable = 1'b0; halt = 1'b0; toggle_clear = 1'b0;
        device_addr = ADDR; endpoint = EP;
        in_buttons = 8'd0; in_dx = 8'd0; in_dy = 8'd0; in_wheel = 8'd0; in_update = 1'b0;
        tok_valid = 1'b0; tok_pid = 4'd0; tok_addr = 7'd0; tok_endp = 4'd0;
        hs_valid = 1'b0; hs_pid = 4'd0; tx_data_ready = 1'b1; tx_done = 1'b0;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        check_state("post_reset");

        // 1. Basic report, then ACK.
        upd(8'h01, 5, -3, 0);
        check_state("t1_pending");
        token(ADDR, EP, -1, 0, -1);
        check("t1_pid_literal",   {28'd0, cap_pid}, {28'd0, PID_DATA0});
        check("t1_bytes_literal", cap, 32'h00FD_0501);
        hs(PID_ACK);
        check("t1_toggle_literal", {31'd0, data_toggle}, 32'd1);
        check("t1_acks_literal",   {16'd0, ack_count},   32'd1);
        check_state("t1_end");

        // 2. Nothing to report gives NAK. Foreign tokens are ignored.
        token(ADDR, EP, -1, 0, -1);
        check("t2_nak_literal", {28'd0, cap_pid}, {28'd0, PID_NAK});
        token(7'h16, EP, -1, 0, -1);
        token(ADDR, 4'h2, -1, 0, -1);
        upd(8'h01, 0, 0, 0);            // same buttons, no motion
        check_state("t2_no_pending");

        // 3. Saturation at +127 and -127, including a -128 input.
        upd(8'h00, 100, 0, 0);
        upd(8'h00, 100, 0, 0);
        token(ADDR, EP, -1, 0, -1);
        check("t3_x_pos_sat", {24'd0, cap[1]}, 32'h7F);
        hs(PID_ACK);
        upd(8'h00, -100, -128, 0);
        upd(8'h00, -100, 0, 0);
        token(ADDR, EP, -1, 0, -1);
        check("t3_x_neg_sat", {24'd0, cap[1]}, 32'h81);
        check("t3_y_neg_sat", {24'd0, cap[2]}, 32'h81);
        hs(PID_ACK);
        check_state("t3_end");

        // 4. Timeout and non-ACK handshake both lead to an identical resend.
        pulse_toggle_clear();
        upd(8'h02, 1, 1, 0);
        token(ADDR, EP, -1, 0, -1);
        repeat (TO + 5) tick();
        token(ADDR, EP, -1, 0, -1);
        check("t4_resend_pid", {28'd0, cap_pid}, {28'd0, PID_DATA0});
        check("t4_resend_bytes", cap, 32'h0001_0102);
        hs(PID_NAK);
        token(ADDR, EP, -1, 0, -1);
        hs(PID_ACK);
        check("t4_toggle_literal", {31'd0, data_toggle}, 32'd1);
        check_state("t4_end");

        // 5. Halt gives STALL. Pending data and a held snapshot both survive.
        upd(8'h04, 2, 0, 0);
        halt = 1'b1;
        token(ADDR, EP, -1, 0, -1);
        check("t5_stall_literal", {28'd0, cap_pid}, {28'd0, PID_STALL});
        check("t5_pending_kept", {31'd0, report_pending}, 32'd1);
        pulse_toggle_clear();
        halt = 1'b0;
        token(ADDR, EP, -1, 0, -1);
        check("t5_data0_literal", {28'd0, cap_pid}, {28'd0, PID_DATA0});
        hs(PID_ACK);
        upd(8'h05, 0, 0, 0);
        token(ADDR, EP, -1, 0, -1);
        repeat (TO + 5) tick();
        halt = 1'b1;
        token(ADDR, EP, -1, 0, -1);
        halt = 1'b0;
        token(ADDR, EP, -1, 0, -1);
        check("t5_resend_after_stall", cap, 32'h0000_0005);
        hs(PID_ACK);
        check_state("t5_end");

        // 6. Backpressure mid-packet, then abort by dropping enable.
        upd(8'h08, 3, 4, 5);
        token(ADDR, EP, 2, 10, -1);
        hs(PID_ACK);
        check_state("t6_stall_end");
        upd(8'h10, 1, 1, 1);
        token(ADDR, EP, -1, 0, 1);
        @(negedge clk);
        check_all_zero("t6_disabled");
        tick();
        model_reset();
        repeat (3) tick();
        enable = 1'b1;
        tick();
        check_state("t6_reenabled");
        token(ADDR, EP, -1, 0, -1);
        check("t6_nak_after_abort", {28'd0, cap_pid}, {28'd0, PID_NAK});

        repeat (3) tick();
        check("exp_queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
